// File: rtl/stream_block_sequencer_pkg.sv
// Shared state encoding, FIFO entry layout and pad-byte rule for stream_block_sequencer.
// Padding rule: SEQ_PKCS_PAD_EN defined = PKCS#7 style, undefined = zero padding.
package stream_block_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_REQ,
    ST_WAIT,
    ST_PAD,
    ST_FLUSH,
    ST_ERR
  } state_e;

`ifdef SEQ_PKCS_PAD_EN
  localparam bit PKCS_PAD = 1'b1;
`else
  localparam bit PKCS_PAD = 1'b0;
`endif

  localparam int unsigned DEF_BLOCK_SIZE = 64;

  typedef struct packed {
    logic [DEF_BLOCK_SIZE-1:0] data;
    logic                      last;
  } fifo_entry_t;

  // Value written into each missing byte, given how many bytes are missing.
  function automatic logic [7:0] pad_byte(input logic [7:0] missing);
    return missing & {8{PKCS_PAD}};
  endfunction

endpackage

// File: rtl/stream_block_sequencer_blk_fifo2.sv
// Two-entry FIFO holding padded blocks between the reader and the cipher core.
// Push and pop may coincide, including push while full when a pop frees the head.
module blk_fifo2
  import stream_block_sequencer_pkg::*;
#(
  parameter type entry_t = fifo_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic       clear,
  input  entry_t     din,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t mem [2];
  logic   rptr;
  logic   wsel;

  // With two slots the write slot is rptr^count[0]; when full this is the head being popped.
  assign wsel = rptr ^ count[0];
  assign head = mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rptr   <= 1'b0;
      count  <= '0;
    end else if (clear) begin
      rptr  <= 1'b0;
      count <= '0;
    end else begin
      if (push) mem[wsel] <= din;
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/stream_block_sequencer.sv
// Reader-to-cipher block sequencer: one read outstanding, 2-deep prefetch, final-block padding.
// Padding rule selected by SEQ_PKCS_PAD_EN (PKCS#7 when defined, zero padding otherwise).
module stream_block_sequencer
  import stream_block_sequencer_pkg::*;
#(
  parameter int unsigned BLOCK_SIZE = 64,
  parameter int unsigned TIMEOUT    = 1024,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              go,
  input  logic                              abort,
  output logic                              rd_start,
  output logic                              rd_req,
  input  logic                              rd_valid,
  input  logic [BLOCK_SIZE-1:0]             rd_data,
  input  logic [$clog2(BLOCK_SIZE/8):0]     rd_bytes,
  input  logic                              rd_last,
  output logic                              core_valid,
  input  logic                              core_ready,
  output logic [BLOCK_SIZE-1:0]             core_data,
  output logic                              core_last,
  output logic                              busy,
  output logic                              done,
  output logic                              timeout_err,
  output logic [CNT_W-1:0]                  blk_count
);

  localparam int unsigned NB = BLOCK_SIZE / 8;
  localparam int unsigned BW = $clog2(NB) + 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Same layout as fifo_entry_t, sized to this instance's block width.
  typedef struct packed {
    logic [BLOCK_SIZE-1:0] data;
    logic                  last;
  } blk_entry_t;

  state_e                state;
  logic [TW-1:0]         tcnt;
  logic [1:0]            count, cnt_next;
  logic                  push, pop, clear, rd_push, pad_push, rd_keep, tmo_hit;
  logic [BLOCK_SIZE-1:0] rd_padded, pad_data;
  blk_entry_t            head, rd_entry, pad_entry, push_entry;

  always_comb begin
    rd_padded = '0;
    pad_data  = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      pad_data[BLOCK_SIZE-1-8*i -: 8] = pad_byte(8'(NB));
      if (i < 32'(rd_bytes)) rd_padded[BLOCK_SIZE-1-8*i -: 8] = rd_data[BLOCK_SIZE-1-8*i -: 8];
      else                   rd_padded[BLOCK_SIZE-1-8*i -: 8] = pad_byte(8'(NB - 32'(rd_bytes)));
    end
  end

`ifdef SEQ_PKCS_PAD_EN
  logic fin_full;
  assign fin_full = (rd_bytes == BW'(NB));
  assign rd_keep  = 1'b1;
  assign rd_entry = '{data: rd_padded, last: rd_last && !fin_full};
`else
  assign rd_keep  = !(rd_last && (rd_bytes == '0));
  assign rd_entry = '{data: rd_padded, last: rd_last};
`endif

  assign pad_entry  = '{data: pad_data, last: 1'b1};
  assign pop        = core_valid && core_ready;
  assign rd_push    = (state == ST_WAIT) && rd_valid && rd_keep;
  // The pad block may arrive while both slots hold data; it waits for a slot or a same-cycle pop.
  assign pad_push   = (state == ST_PAD) && ((count != 2'd2) || pop);
  assign push       = (rd_push || pad_push) && !abort;
  assign push_entry = pad_push ? pad_entry : rd_entry;
  assign tmo_hit    = (state == ST_WAIT) && !rd_valid && (tcnt == TW'(TIMEOUT - 1));
  assign clear      = abort || tmo_hit;
  assign cnt_next   = count + {1'b0, push} - {1'b0, pop};

  blk_fifo2 #(.entry_t(blk_entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (clear),
    .din   (push_entry),
    .count (count),
    .head  (head)
  );

  assign core_valid = (count != 2'd0);
  assign core_data  = head.data;
  assign core_last  = head.last;
  assign busy       = (state != ST_IDLE) && (state != ST_ERR);

  // Requests are issued on the edge that would enter REQ when space allows, so rd_req lands one cycle after rd_valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      tcnt        <= '0;
      rd_start    <= 1'b0;
      rd_req      <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      blk_count   <= '0;
    end else begin
      rd_start <= 1'b0;
      rd_req   <= 1'b0;
      done     <= 1'b0;
      if (pop && (blk_count != '1)) blk_count <= blk_count + CNT_W'(1);
      if (abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_ERR: begin
            if (go) begin
              state       <= ST_START;
              rd_start    <= 1'b1;
              blk_count   <= '0;
              timeout_err <= 1'b0;
            end
          end
          ST_START, ST_REQ: begin
            if (cnt_next <= 2'd1) begin
              state  <= ST_WAIT;
              rd_req <= 1'b1;
              tcnt   <= '0;
            end else begin
              state <= ST_REQ;
            end
          end
          ST_WAIT: begin
            if (rd_valid) begin
              if (!rd_last) begin
                if (cnt_next <= 2'd1) begin
                  rd_req <= 1'b1;
                  tcnt   <= '0;
                end else begin
                  state <= ST_REQ;
                end
              end
`ifdef SEQ_PKCS_PAD_EN
              else if (fin_full) state <= ST_PAD;
`endif
              else state <= ST_FLUSH;
            end else if (tmo_hit) begin
              state       <= ST_ERR;
              timeout_err <= 1'b1;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
          ST_PAD: begin
            if (pad_push) state <= ST_FLUSH;
          end
          ST_FLUSH: begin
            if (cnt_next == 2'd0) begin
              done  <= 1'b1;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stream_block_sequencer.sv
// Directed self-checking bench for stream_block_sequencer (BLOCK_SIZE=64, TIMEOUT=16, CNT_W=4).
// Expectations follow SEQ_PKCS_PAD_EN when the bench is built with it defined.
module tb_stream_block_sequencer;

  localparam int unsigned BS  = 64;
  localparam int unsigned TMO = 16;
  localparam int unsigned CW  = 4;

`ifdef SEQ_PKCS_PAD_EN
  localparam bit PKCS = 1'b1;
`else
  localparam bit PKCS = 1'b0;
`endif

  localparam logic [63:0] FULL_PAD = 64'h0808080808080808;

  logic          clk = 1'b0;
  logic          rst, go, abort, rd_valid, rd_last, core_ready;
  logic          rd_start, rd_req, core_valid, core_last, busy, done, timeout_err;
  logic [BS-1:0] rd_data, core_data;
  logic [3:0]    rd_bytes;
  logic [CW-1:0] blk_count;

  int tests = 0;
  int fails = 0;

  int          n_done = 0;
  int          n_req  = 0;
  logic [63:0] pop_data[$];
  logic        pop_last[$];

  always #5 clk = ~clk;

  stream_block_sequencer #(.BLOCK_SIZE(BS), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .abort      (abort),
    .rd_start   (rd_start),
    .rd_req     (rd_req),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_bytes   (rd_bytes),
    .rd_last    (rd_last),
    .core_valid (core_valid),
    .core_ready (core_ready),
    .core_data  (core_data),
    .core_last  (core_last),
    .busy       (busy),
    .done       (done),
    .timeout_err(timeout_err),
    .blk_count  (blk_count)
  );

  always @(negedge clk) begin
    if (core_valid && core_ready) begin
      pop_data.push_back(core_data);
      pop_last.push_back(core_last);
    end
    if (done) n_done++;
    if (rd_req) n_req++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (rd_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (n_done != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic send_block(input logic [63:0] d, input logic [3:0] b, input logic l);
    rd_data  = d;
    rd_bytes = b;
    rd_last  = l;
    rd_valid = 1'b1;
    tick();
    rd_valid = 1'b0;
    rd_last  = 1'b0;
    rd_bytes = '0;
    rd_data  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; go = 1'b0; abort = 1'b0; rd_valid = 1'b0; rd_last = 1'b0;
    rd_bytes = '0; rd_data = '0; core_ready = 1'b0;
    #12;
    tests++;
    if ({rd_start, rd_req, core_valid, core_last, busy, done, timeout_err} !== 7'b0) begin
      fails++;
      $display("FAIL reset_ctrl got %b want 0000000",
               {rd_start, rd_req, core_valid, core_last, busy, done, timeout_err});
    end
    tests++;
    if (core_data !== 64'h0) begin fails++; $display("FAIL reset_data got %h want 0", core_data); end
    tests++;
    if (blk_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", blk_count); end
    @(negedge clk);
    rst = 1'b0;
    tick(); tick();
    tests++;
    if ({busy, rd_start} !== 2'b00) begin fails++; $display("FAIL reset_idle got %b want 00", {busy, rd_start}); end
  endtask

  task automatic test_saturate();
    bit ok;
    int bd;
    bd = n_done;
    core_ready = 1'b1;
    go = 1'b1; tick(); go = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 17; i++) begin
      wait_req(ok);
      if (!ok) break;
      send_block(64'h1000 + 64'(i), 4'd8, i == 16);
    end
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL sat_req got no rd_req want rd_req within 60 cycles"); end
    wait_done(bd, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL sat_done got no done want done within 60 cycles"); end
    tests++;
    if (blk_count !== 4'd15) begin fails++; $display("FAIL sat_count got %0d want 15", blk_count); end
  endtask

  task automatic test_full_stream();
    logic [63:0] exp_d[4];
    logic        exp_l[4];
    int          b, bd, nexp;
    exp_d = '{64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0123456789ABCDEF, FULL_PAD};
    exp_l = '{1'b0, 1'b0, !PKCS, 1'b1};
    nexp  = PKCS ? 4 : 3;
    b  = pop_data.size();
    bd = n_done;
    core_ready = 1'b1;
    go = 1'b1; tick(); go = 1'b0;
    tests++;
    if ({rd_start, rd_req} !== 2'b10) begin fails++; $display("FAIL start_strobe got %b want 10", {rd_start, rd_req}); end
    tests++;
    if (blk_count !== 4'd0) begin fails++; $display("FAIL count_clear got %0d want 0", blk_count); end
    tick();
    tests++;
    if (rd_req !== 1'b1) begin fails++; $display("FAIL first_req got %b want 1", rd_req); end
    send_block(exp_d[0], 4'd8, 1'b0);
    tests++;
    if (core_valid !== 1'b1) begin fails++; $display("FAIL valid_latency got %b want 1", core_valid); end
    tests++;
    if (rd_req !== 1'b1) begin fails++; $display("FAIL b2b_req got %b want 1", rd_req); end
    send_block(exp_d[1], 4'd8, 1'b0);
    send_block(exp_d[2], 4'd8, 1'b1);
    repeat (PKCS ? 2 : 1) tick();
    tests++;
    if (done !== 1'b1) begin fails++; $display("FAIL done_timing got %b want 1", done); end
    repeat (3) tick();
    tests++;
    if (n_done - bd !== 1) begin fails++; $display("FAIL done_once got %0d want 1", n_done - bd); end
    tests++;
    if (pop_data.size() - b !== nexp) begin
      fails++; $display("FAIL full_pops got %0d want %0d", pop_data.size() - b, nexp);
    end
    for (int i = 0; i < nexp; i++) begin
      if (pop_data.size() > b + i) begin
        tests++;
        if ({pop_data[b+i], pop_last[b+i]} !== {exp_d[i], exp_l[i]}) begin
          fails++;
          $display("FAIL full_blk%0d got %h/%b want %h/%b", i, pop_data[b+i], pop_last[b+i], exp_d[i], exp_l[i]);
        end
      end
    end
    tests++;
    if (blk_count !== 4'(nexp)) begin fails++; $display("FAIL full_count got %0d want %0d", blk_count, nexp); end
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL full_busy got %b want 0", busy); end
  endtask

  task automatic test_partial();
    logic [63:0] exp;
    int          b, bd;
    bit          ok;
    exp = PKCS ? 64'hAABBCC0505050505 : 64'hAABBCC0000000000;
    b  = pop_data.size();
    bd = n_done;
    core_ready = 1'b1;
    go = 1'b1; tick(); go = 1'b0;
    wait_req(ok);
    send_block(64'hAABBCCDDEEFF1122, 4'd3, 1'b1);
    wait_done(bd, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL part_done got no done want done"); end
    tests++;
    if (pop_data.size() - b !== 1) begin
      fails++; $display("FAIL part_pops got %0d want 1", pop_data.size() - b);
    end else begin
      tests++;
      if ({pop_data[b], pop_last[b]} !== {exp, 1'b1}) begin
        fails++; $display("FAIL part_data got %h/%b want %h/1", pop_data[b], pop_last[b], exp);
      end
    end
  endtask

  task automatic test_zero_final();
    logic [63:0] exp_d;
    logic        exp_l;
    int          b, bd;
    bit          ok;
    exp_d = PKCS ? FULL_PAD : 64'hCAFEF00DDEADBEEF;
    exp_l = PKCS;
    b  = pop_data.size();
    bd = n_done;
    core_ready = 1'b1;
    go = 1'b1; tick(); go = 1'b0;
    wait_req(ok);
    send_block(64'hCAFEF00DDEADBEEF, 4'd8, 1'b0);
    wait_req(ok);
    send_block(64'hFFFFFFFFFFFFFFFF, 4'd0, 1'b1);
    wait_done(bd, ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL zero_done got no done want done"); end
    tests++;
    if (pop_data.size() - b !== (PKCS ? 2 : 1)) begin
      fails++; $display("FAIL zero_pops got %0d want %0d", pop_data.size() - b, PKCS ? 2 : 1);
    end else begin
      tests++;
      if ({pop_data[$], pop_last[$]} !== {exp_d, exp_l}) begin
        fails++; $display("FAIL zero_tail got %h/%b want %h/%b", pop_data[$], pop_last[$], exp_d, exp_l);
      end
    end
  endtask

  task automatic test_backpressure();
    int breq;
    bit ok, stable;
    breq = n_req;
    core_ready = 1'b0;
    go = 1'b1; tick(); go = 1'b0;
    tick();
    send_block(64'hE0E0E0E0E0E0E0E0, 4'd8, 1'b0);
    send_block(64'hE1E1E1E1E1E1E1E1, 4'd8, 1'b0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (core_valid !== 1'b1 || core_data !== 64'hE0E0E0E0E0E0E0E0) stable = 1'b0;
    end
    tests++;
    if (stable !== 1'b1) begin fails++; $display("FAIL bp_stable got %h want e0e0e0e0e0e0e0e0", core_data); end
    tests++;
    if (n_req - breq !== 2) begin fails++; $display("FAIL bp_req_full got %0d want 2", n_req - breq); end
    core_ready = 1'b1; tick(); core_ready = 1'b0;
    wait_req(ok);
    tests++;
    if (ok !== 1'b1) begin fails++; $display("FAIL bp_req_after_pop got none want rd_req"); end
    send_block(64'hE2E2E2E2E2E2E2E2, 4'd8, 1'b0);
    repeat (10) tick();
    tests++;
    if (n_req - breq !== 3) begin fails++; $display("FAIL bp_one_more got %0d want 3", n_req - breq); end
    tests++;
    if ({core_valid, core_data} !== {1'b1, 64'hE1E1E1E1E1E1E1E1}) begin
      fails++; $display("FAIL bp_head got %b/%h want 1/e1e1e1e1e1e1e1e1", core_valid, core_data);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_timeout();
    go = 1'b1; tick(); go = 1'b0;
    tick();
    repeat (15) tick();
    tests++;
    if ({busy, timeout_err} !== 2'b10) begin fails++; $display("FAIL tmo_early got %b want 10", {busy, timeout_err}); end
    tick();
    tests++;
    if ({busy, timeout_err} !== 2'b01) begin fails++; $display("FAIL tmo_err got %b want 01", {busy, timeout_err}); end
    go = 1'b1; tick(); go = 1'b0;
    tests++;
    if ({rd_start, timeout_err, busy} !== 3'b101) begin
      fails++; $display("FAIL tmo_restart got %b want 101", {rd_start, timeout_err, busy});
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort();
    int bd;
    bd = n_done;
    core_ready = 1'b0;
    go = 1'b1; tick(); go = 1'b0;
    tick();
    send_block(64'hABABABABABABABAB, 4'd8, 1'b0);
    abort    = 1'b1;
    rd_valid = 1'b1; rd_bytes = 4'd8; rd_last = 1'b1; rd_data = 64'h1;
    tick();
    abort = 1'b0; rd_valid = 1'b0; rd_last = 1'b0;
    tests++;
    if ({busy, core_valid, rd_req} !== 3'b000) begin
      fails++; $display("FAIL abort_idle got %b want 000", {busy, core_valid, rd_req});
    end
    send_block(64'h2, 4'd8, 1'b0);
    repeat (4) tick();
    tests++;
    if ({core_valid, busy} !== 2'b00) begin fails++; $display("FAIL abort_ignore got %b want 00", {core_valid, busy}); end
    tests++;
    if (n_done - bd !== 0) begin fails++; $display("FAIL abort_no_done got %0d want 0", n_done - bd); end
  endtask

  task automatic test_rst_mid();
    core_ready = 1'b0;
    go = 1'b1; tick(); go = 1'b0;
    tick();
    send_block(64'h5A5A5A5A5A5A5A5A, 4'd8, 1'b0);
    #2 rst = 1'b1;
    #1;
    tests++;
    if ({rd_start, rd_req, core_valid, core_last, busy, done, timeout_err, core_data, blk_count} !== '0) begin
      fails++;
      $display("FAIL rst_async got %b/%h/%0d want 0000000/0/0",
               {rd_start, rd_req, core_valid, core_last, busy, done, timeout_err}, core_data, blk_count);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    send_block(64'h77, 4'd8, 1'b1);
    tests++;
    if ({core_valid, busy} !== 2'b00) begin fails++; $display("FAIL rst_ignore got %b want 00", {core_valid, busy}); end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_full_stream();
    test_partial();
    test_zero_final();
    test_backpressure();
    test_timeout();
    test_abort();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
